// File: rtl/hsc_tdc_mux_if.sv
// Measurement-side bundle of the TDC core: launch controls and sample tag in,
// hamming weight and aligned tag out.
interface hsc_tdc_mux_if #(
    parameter int HW_W = 7
) ();
    logic            pg_src;
    logic            pg_bypass;
    logic            pg_in;
    logic            pg_tog;
    logic            val_in;
    logic [HW_W-1:0] hw;
    logic            val_out;

    // No handshake: every clk_capture edge produces an output. val_out is a
    // tag marking which hw samples the driver cares about, not a valid/ready pair.
    modport master (
        output pg_src, pg_bypass, pg_in, pg_tog, val_in,
        input  hw, val_out
    );

    modport slave (
        input  pg_src, pg_bypass, pg_in, pg_tog, val_in,
        output hw, val_out
    );
endinterface

// File: rtl/hsc_tdc_mux_core.sv
// Time-to-digital converter core: the launch edge runs down a chain of 2:1 mux
// cells, clk_capture snapshots the taps and the popcount of the snapshot is the time.
module hsc_tdc_mux_core #(
    parameter int N_TAPS = 127,
    parameter int HW_W   = 7
) (
    input  logic          clk_launch,
    input  logic          rst_n,
    input  logic          clk_capture,
    hsc_tdc_mux_if.slave  bus
);

    logic              pg_sel;
    logic              launch;
    logic              launch_d, launch_q;
    logic [N_TAPS-1:0] tap_d, tap_q;
    logic              val_pipe_d, val_pipe_q;
    logic [HW_W-1:0]   hw_d, hw_q;
    logic              val_out_d, val_out_q;

    (* keep = "true", dont_touch = "true" *) logic [N_TAPS-1:0] tap;

    // Launch domain: optional one-flop retime of the selected launch source.
    always_comb begin
        pg_sel   = bus.pg_src ? bus.pg_tog : bus.pg_in;
        launch_d = rst_n ? pg_sel : 1'b0;
        launch   = bus.pg_bypass ? pg_sel : launch_q;
    end

    always_ff @(posedge clk_launch) begin
        launch_q <= launch_d;
    end

    // Each cell is a 2:1 mux with both data legs on the previous tap, so the
    // logic value passes straight through while the cell adds real delay.
    always_comb begin
        tap    = '0;
        tap[0] = launch ? launch : launch;
        for (int i = 1; i < N_TAPS; i++) begin
            tap[i] = tap[i-1] ? tap[i-1] : tap[i-1];
        end
    end

    // Capture domain. No synchronizer on the taps: sampling an edge in flight
    // is the measurement itself.
    always_comb begin
        tap_d      = rst_n ? tap : '0;
        val_pipe_d = rst_n ? bus.val_in : 1'b0;
        val_out_d  = rst_n ? val_pipe_q : 1'b0;
        hw_d       = '0;
        if (rst_n) begin
            for (int i = 0; i < N_TAPS; i++) begin
                hw_d = hw_d + HW_W'(tap_q[i]);
            end
        end
    end

    always_ff @(posedge clk_capture) begin
        tap_q      <= tap_d;
        val_pipe_q <= val_pipe_d;
        hw_q       <= hw_d;
        val_out_q  <= val_out_d;
    end

    assign bus.hw      = hw_q;
    assign bus.val_out = val_out_q;

endmodule

// File: tb/tb_hsc_tdc_mux_core.sv
// Bench for hsc_tdc_mux_core: directed launch scenarios then randomized
// traffic, all outputs checked against a tap-free behavioural model.
`timescale 1ns/10ps
module tb_hsc_tdc_mux_core;

    localparam int N_TAPS = 127;
    localparam int HW_W   = 7;
    localparam int W      = HW_W + 1;

    // ---------------- clock / reset ----------------
    logic clk_launch  = 1'b0;
    logic clk_capture = 1'b0;
    logic rst_n       = 1'b0;
    logic launch_run  = 1'b1;
    logic tog_en      = 1'b0;

    hsc_tdc_mux_if #(.HW_W(HW_W)) bus ();

    hsc_tdc_mux_core #(.N_TAPS(N_TAPS), .HW_W(HW_W)) dut (
        .clk_launch  (clk_launch),
        .rst_n       (rst_n),
        .clk_capture (clk_capture),
        .bus         (bus)
    );

    // Launch edges at multiples of 5 ns, capture edges at 2.5 + 3.6k ns: the
    // two never coincide, and stimulus lands on x.x5 ns so it never hits an edge.
    always begin
        #5;
        if (launch_run) clk_launch = ~clk_launch;
    end

    initial begin
        #2.5;
        forever begin
            clk_capture = ~clk_capture;
            #3.6;
        end
    end

    // External clk_launch/4 divider for pg_tog.
    int tog_cnt = 0;
    always @(posedge clk_launch) begin
        #0.05;
        if (tog_en) begin
            tog_cnt = tog_cnt + 1;
            if (tog_cnt % 2 == 0) bus.pg_tog = ~bus.pg_tog;
        end
    end

    // ---------------- reference model + scoreboard ----------------
    logic [W-1:0] exp_q[$];
    int tests_run = 0;
    int fails     = 0;

    bit       m_launch_reg = 1'b0;
    bit [W-1:0] m_snap     = '0;  // {val, hw} that the snapshot will yield

    function automatic bit model_sel();
        return bus.pg_src ? bus.pg_tog : bus.pg_in;
    endfunction

    always @(posedge clk_launch) begin
        m_launch_reg = rst_n ? model_sel() : 1'b0;
    end

    // Zero-delay chain: every tap equals the launch level, so a snapshot
    // weighs either all N_TAPS or nothing.
    always @(posedge clk_capture) begin
        bit launch_now;
        launch_now = bus.pg_bypass ? model_sel() : m_launch_reg;
        if (!rst_n) begin
            exp_q.push_back('0);
            m_snap = '0;
        end else begin
            exp_q.push_back(m_snap);
            m_snap = {bus.val_in, launch_now ? HW_W'(N_TAPS) : HW_W'(0)};
        end
    end

    int seen_hi = 0;
    int seen_lo = 0;

    always @(negedge clk_capture) begin
        logic [W-1:0] exp_v;
        if (exp_q.size() > 0) begin
            exp_v = exp_q.pop_front();
            tests_run++;
            if ({bus.val_out, bus.hw} !== exp_v) begin
                fails++;
                $display("FAIL sb t=%0t hw=%0d val_out=%0b expected hw=%0d val_out=%0b",
                         $time, bus.hw, bus.val_out, exp_v[HW_W-1:0], exp_v[HW_W]);
            end
            if (tog_en) begin
                if (bus.hw == HW_W'(N_TAPS)) seen_hi++;
                if (bus.hw == '0) seen_lo++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic check(input string name, input int act, input int exp_v);
        tests_run++;
        if (act !== exp_v) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d", name, act, exp_v);
        end
    endtask

    task automatic step_drive();
        @(negedge clk_capture);
        #0.05;
    endtask

    task automatic wait_capture2();
        @(posedge clk_capture);
        @(posedge clk_capture);
        @(negedge clk_capture);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.pg_src    = 1'b0;
        bus.pg_bypass = 1'b0;
        bus.pg_in     = 1'b0;
        bus.pg_tog    = 1'b0;
        bus.val_in    = 1'b0;

        // Reset held over several edges of both clocks.
        repeat (6) @(negedge clk_capture);
        check("reset_hw", int'(bus.hw), 0);
        check("reset_val", int'(bus.val_out), 0);

        // Registered launch, rising.
        step_drive();
        rst_n      = 1'b1;
        bus.pg_in  = 1'b1;
        bus.val_in = 1'b1;
        @(posedge clk_launch);
        wait_capture2();
        check("reg_rise_hw", int'(bus.hw), N_TAPS);
        check("reg_rise_val", int'(bus.val_out), 1);

        // Registered launch, falling.
        step_drive();
        bus.pg_in  = 1'b0;
        bus.val_in = 1'b0;
        @(posedge clk_launch);
        wait_capture2();
        check("reg_fall_hw", int'(bus.hw), 0);
        check("reg_fall_val", int'(bus.val_out), 0);

        // Bypass with the launch clock stopped.
        step_drive();
        launch_run    = 1'b0;
        bus.pg_bypass = 1'b1;
        bus.pg_in     = 1'b1;
        wait_capture2();
        check("bypass_hi_hw", int'(bus.hw), N_TAPS);
        step_drive();
        bus.pg_in = 1'b0;
        wait_capture2();
        check("bypass_lo_hw", int'(bus.hw), 0);

        // Toggle source through the launch register.
        step_drive();
        launch_run    = 1'b1;
        bus.pg_bypass = 1'b0;
        bus.pg_src    = 1'b1;
        tog_en        = 1'b1;
        repeat (60) @(negedge clk_capture);
        tog_en = 1'b0;
        check("tog_seen_hi", int'(seen_hi > 0), 1);
        check("tog_seen_lo", int'(seen_lo > 0), 1);

        // Reset mid-stream while hw is full scale.
        step_drive();
        bus.pg_src    = 1'b0;
        bus.pg_bypass = 1'b1;
        bus.pg_in     = 1'b1;
        bus.val_in    = 1'b1;
        wait_capture2();
        check("pre_rst_hw", int'(bus.hw), N_TAPS);
        step_drive();
        rst_n = 1'b0;
        @(posedge clk_capture);
        @(negedge clk_capture);
        check("mid_rst_hw", int'(bus.hw), 0);
        check("mid_rst_val", int'(bus.val_out), 0);
        repeat (3) @(negedge clk_capture);
        #0.05;
        rst_n = 1'b1;

        // Randomized traffic, including occasional reset pulses and clock stalls.
        for (int i = 0; i < 400; i++) begin
            step_drive();
            bus.pg_src    = 1'($urandom_range(0, 1));
            bus.pg_bypass = 1'($urandom_range(0, 1));
            bus.pg_in     = 1'($urandom_range(0, 1));
            bus.pg_tog    = 1'($urandom_range(0, 1));
            bus.val_in    = 1'($urandom_range(0, 1));
            launch_run    = ($urandom_range(0, 9) != 0);
            rst_n         = ($urandom_range(0, 29) != 0);
        end
        step_drive();
        rst_n      = 1'b1;
        launch_run = 1'b1;
        repeat (4) @(negedge clk_capture);

        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
